// File: rtl/noc_local_inject_arbiter.sv
// Round-robin wormhole injection arbiter in front of a router's local input port.
// A head flit wins the port and its source keeps it until that source's tail flit is accepted.
module noc_local_inject_arbiter #(
    parameter int NumReq = 4,
    parameter int Width  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NumReq-1:0]          req_valid,
    input  logic [NumReq*Width-1:0]    req_data,
    output logic [NumReq-1:0]          req_ready,
    output logic [Width-1:0]           data_p_out,
    output logic                       data_void_out,
    input  logic                       stop_in,
    output logic [$clog2(NumReq)-1:0]  owner,
    output logic                       locked,
    output logic [15:0]                pkt_count,
    output logic                       proto_err
);

    // Handshake: a source flit moves on req_valid[i] && req_ready[i]; a flit moves to the
    // router on !data_void_out && !stop_in. req_ready is combinational on valid and stop_in.

    localparam int IdxW = $clog2(NumReq);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [Width-1:0]  out_data_q, out_data_d;
    logic              out_void_q, out_void_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    logic              proto_err_q, proto_err_d;
    logic [NumReq-1:0] stalled_q, stalled_d;

    logic [NumReq-1:0] head_v;
    logic [NumReq-1:0] cand_v;
    logic [NumReq-1:0] grant;
    logic [NumReq-1:0] new_err;
    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   sel_idx;
    logic [Width-1:0]  sel_data;
    logic              sel_tail;
    logic              xfer;
    logic              free;
    logic              accept;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        if (int'(i) == NumReq - 1) begin
            return '0;
        end
        return i + IdxW'(1);
    endfunction

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_head
        assign head_v[gi] = req_data[gi*Width + Width - 1];
    end

    assign xfer = !out_void_q && !stop_in;
    assign free = out_void_q || xfer;

    // Stalled sources have committed a protocol error and are never arbitrated again.
    assign cand_v = req_valid & head_v & ~stalled_q;

    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!win_found && cand_v[IdxW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == ST_IDLE) begin
            if (win_found) begin
                grant[win_idx] = 1'b1;
            end
        end else if (req_valid[owner_q] && !head_v[owner_q] && !stalled_q[owner_q]) begin
            grant[owner_q] = 1'b1;
        end
    end

    assign sel_idx   = (state_q == ST_LOCKED) ? owner_q : win_idx;
    assign req_ready = rst ? '0 : (grant & req_valid & {NumReq{free}});
    assign accept    = |req_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (sel_idx == IdxW'(i)) begin
                sel_data = req_data[i*Width +: Width];
            end
        end
    end

    assign sel_tail = sel_data[Width-2];

    // Body flits with no packet open, or a head from the owner mid-packet, are illegal.
    always_comb begin
        new_err = '0;
        if (state_q == ST_IDLE) begin
            new_err = req_valid & ~head_v & ~stalled_q;
        end else if (req_valid[owner_q] && head_v[owner_q] && !stalled_q[owner_q]) begin
            new_err[owner_q] = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = win_idx;
                    if (sel_tail) begin
                        rr_ptr_d = next_idx(win_idx);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept && sel_tail) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(owner_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        locked = (state_q == ST_LOCKED);
        owner  = owner_q;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_void_d  = out_void_q;
        pkt_count_d = pkt_count_q;
        if (accept) begin
            out_data_d = sel_data;
            out_void_d = 1'b0;
        end else if (xfer) begin
            out_void_d = 1'b1;
        end
        if (xfer && out_data_q[Width-2]) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
        stalled_d   = stalled_q | new_err;
        proto_err_d = proto_err_q | (|new_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_void_q  <= 1'b1;
            pkt_count_q <= '0;
            proto_err_q <= 1'b0;
            stalled_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_void_q  <= out_void_d;
            pkt_count_q <= pkt_count_d;
            proto_err_q <= proto_err_d;
            stalled_q   <= stalled_d;
        end
    end

    assign data_p_out    = out_data_q;
    assign data_void_out = out_void_q;
    assign pkt_count     = pkt_count_q;
    assign proto_err     = proto_err_q;

endmodule
